fst1_norm: RTL and testbench

Leading-one normalizer placed directly downstream of the first-1 detector `fst1_sel`. It takes a 32-bit word and the detector's position result, then left-shifts the word so its most-significant 1 lands at bit 31. It emits the shift amount and a zero flag through a 2-stage valid/ready pipeline. It also checks each position against its data word, keeps a sticky error flag, and counts zero words.

---
 rtl/fst1_pkg.sv | 33 +++
 rtl/fst1_norm_lz_shift.sv | 22 ++
 rtl/fst1_norm.sv | 97 +++++++++
 tb/tb_fst1_norm.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fst1_pkg.sv
// fst1_pkg: shared constants and types for the first-1 detector family
// (fst1_sel, fst1_norm).
//   DW       data word width (fixed at 32)
//   PW       position width; POS_NONE marks an all-zero word
//   s1_t     payload held in the normalizer's first pipeline stage
//   pos_check  consistency test of a position against its data word
package fst1_pkg;

  localparam int DW = 32;
  localparam int PW = 6;
  localparam logic [PW-1:0] POS_NONE = 6'd32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [PW-1:0] pos;
    logic          chk_ok;
  } s1_t;

  // For a real index the word shifted down by pos must be exactly 1:
  // that covers both "bit pos is set" and "nothing above it is set".
  function automatic logic pos_check(input logic [DW-1:0] data,
                                     input logic [PW-1:0] pos);
    logic ok;
    if (pos < POS_NONE)
      ok = ((data >> pos[4:0]) == {{(DW-1){1'b0}}, 1'b1});
    else if (pos == POS_NONE)
      ok = (data == '0);
    else
      ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/fst1_norm_lz_shift.sv
// lz_shift: combinational 32-bit left barrel shifter, zero fill.
//   data    word to shift
//   amt     shift amount 0..31
//   result  data << amt, truncated to 32 bits
module lz_shift
  import fst1_pkg::*;
(
  input  logic [DW-1:0] data,
  input  logic [4:0]    amt,
  output logic [DW-1:0] result
);

  always_comb begin
    result = data;
    if (amt[0]) result = result << 1;
    if (amt[1]) result = result << 2;
    if (amt[2]) result = result << 4;
    if (amt[3]) result = result << 8;
    if (amt[4]) result = result << 16;
  end

endmodule

// File: rtl/fst1_norm.sv
// fst1_norm: leading-one normalizer behind fst1_sel. Left-shifts the word
// so its most-significant 1 lands at bit 31, through a 2-stage valid/ready
// pipeline, with a sticky position/data mismatch flag and a saturating
// zero-word counter.
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             input handshake
//   in_data, in_pos               word and its first-1 position (32 = zero)
//   out_valid/out_ready           output handshake
//   out_data, out_shift, out_zero normalized word, shift applied, zero flag
//   err                           sticky mismatch flag
//   zero_cnt                      accepted zero words, saturating
module fst1_norm
  import fst1_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [PW-1:0] in_pos,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [4:0]    out_shift,
  output logic          out_zero,
  output logic          err,
  output logic [CW-1:0] zero_cnt
);

  logic          s1_valid;
  s1_t           s1;
  logic          s2_adv;
  logic          s1_adv;
  logic          s1_zero;
  logic          s1_bad;
  logic [4:0]    s1_amt;
  logic [DW-1:0] shift_in;
  logic [DW-1:0] shift_out;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Any position of 32 or more is handled as a zero word; an out-of-range
  // position additionally blanks the data so garbage never leaves the block.
  assign s1_zero  = (s1.pos >= POS_NONE);
  assign s1_bad   = (s1.pos > POS_NONE);
  assign s1_amt   = s1_zero ? 5'd0 : ~s1.pos[4:0];  // 31 - pos
  assign shift_in = s1_bad ? '0 : s1.data;

  lz_shift u_lz_shift (
    .data   (shift_in),
    .amt    (s1_amt),
    .result (shift_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1.data   <= in_data;
        s1.pos    <= in_pos;
        s1.chk_ok <= pos_check(in_data, in_pos);
      end
    end
  end

  // err and zero_cnt only move on the S1->S2 transfer, so a word parked in
  // either stage is seen exactly once.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_shift <= '0;
      out_zero  <= 1'b0;
      err       <= 1'b0;
      zero_cnt  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= shift_out;
        out_shift <= s1_amt;
        out_zero  <= s1_zero;
        if (!s1.chk_ok)
          err <= 1'b1;
        if (s1_zero && (zero_cnt != '1))
          zero_cnt <= zero_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fst1_norm.sv
module tb_fst1_norm;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  shift;
    logic        zero;
    logic        err;
    int          cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [5:0]  in_pos;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_shift;
  logic        out_zero;
  logic        err;
  logic [15:0] zero_cnt;

  logic        in_ready_s;
  logic        out_valid_s;
  logic [31:0] out_data_s;
  logic [4:0]  out_shift_s;
  logic        out_zero_s;
  logic        err_s;
  logic [3:0]  zero_cnt_s;

  int tests = 0;
  int fails = 0;

  exp_t sb[$];
  logic model_err = 1'b0;
  int   model_cnt = 0;
  logic saw_in_ready_low = 1'b0;

  logic        held_valid;
  logic [31:0] held_data;
  logic [4:0]  held_shift;
  logic        held_zero;
  logic        prev_stall = 1'b0;

  always #5 clk = ~clk;

  fst1_norm #(.CW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_pos(in_pos), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_shift(out_shift),
    .out_zero(out_zero), .err(err), .zero_cnt(zero_cnt)
  );

  fst1_norm #(.CW(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_pos(in_pos), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .out_shift(out_shift_s),
    .out_zero(out_zero_s), .err(err_s), .zero_cnt(zero_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written from the word/position definition.
  function automatic exp_t model(input logic [31:0] d, input logic [5:0] p);
    exp_t e;
    logic ok;
    e.err = 1'b0;
    e.cnt = 0;
    if (p < 6'd32) begin
      e.shift = 5'(31 - int'(p));
      e.data  = d << (31 - int'(p));
      e.zero  = 1'b0;
      ok = d[p[4:0]];
      for (int b = 0; b < 32; b++)
        if (b > int'(p) && d[b]) ok = 1'b0;
    end else if (p == 6'd32) begin
      e.shift = 5'd0;
      e.data  = d;
      e.zero  = 1'b1;
      ok = (d == 32'd0);
    end else begin
      e.shift = 5'd0;
      e.data  = 32'd0;
      e.zero  = 1'b1;
      ok = 1'b0;
    end
    if (!ok) model_err = 1'b1;
    if (e.zero && model_cnt < 65535) model_cnt++;
    e.err = model_err;
    e.cnt = model_cnt;
    return e;
  endfunction

  // Monitor: inputs are driven just after posedge, so at negedge the
  // handshakes predict exactly what the next posedge transfers.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      model_err  = 1'b0;
      model_cnt  = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'(held_valid));
        check("stall_data", out_data, held_data);
        check("stall_shift", 32'(out_shift), 32'(held_shift));
        check("stall_zero", 32'(out_zero), 32'(held_zero));
      end
      if (!in_ready) saw_in_ready_low = 1'b1;
      if (in_valid && in_ready)
        sb.push_back(model(in_data, in_pos));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_shift", 32'(out_shift), 32'(e.shift));
          check("out_zero", 32'(out_zero), 32'(e.zero));
          check("err", 32'(err), 32'(e.err));
          check("zero_cnt", 32'(zero_cnt), 32'(e.cnt));
        end
      end
      prev_stall = out_valid && !out_ready;
      held_valid = out_valid;
      held_data  = out_data;
      held_shift = out_shift;
      held_zero  = out_zero;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [5:0] p);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_pos   = p;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_pos = '0;
    out_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_shift", 32'(out_shift), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_zero_cnt", 32'(zero_cnt), 32'd0);
    tick();
    rst = 1'b0;

    // Basic normalization, back-to-back
    send(32'h1880_0000, 6'd28);
    send(32'h00FF_0000, 6'd23);
    send(32'h0000_000A, 6'd3);
    send(32'h8000_0000, 6'd31);
    send(32'h0000_0001, 6'd0);
    drain();
    check("basic_err", 32'(err), 32'd0);

    // Zero words
    send(32'h0, 6'd32);
    send(32'h0, 6'd32);
    drain();
    check("zero_cnt_2", 32'(zero_cnt), 32'd2);

    // Mismatches: err sticks across later good words
    send(32'h00FF_0000, 6'd20);
    send(32'h0000_0100, 6'd8);
    send(32'h1234_5678, 6'd40);
    send(32'h0000_0040, 6'd6);
    drain();
    check("err_sticky", 32'(err), 32'd1);

    // Backpressure: out_ready low for four cycles mid-stream
    saw_in_ready_low = 1'b0;
    fork
      begin
        send(32'h0001_0000, 6'd16);
        send(32'h0, 6'd32);
        send(32'h0000_3000, 6'd13);
        send(32'h4000_0000, 6'd30);
        send(32'h0000_0007, 6'd2);
      end
      begin
        tick();
        tick();
        out_ready = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_in_ready_dropped", 32'(saw_in_ready_low), 32'd1);
    check("bp_zero_once", 32'(zero_cnt), 32'd4);

    // Reset with both stages full
    out_ready = 1'b0;
    send(32'h0000_0F00, 6'd11);
    send(32'h0, 6'd32);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_zero_cnt", 32'(zero_cnt), 32'd0);
    tick();

    // Latency: word presented in one cycle is visible two edges later
    in_valid = 1'b1;
    in_data  = 32'h0000_0300;
    in_pos   = 6'd9;
    @(negedge clk);
    check("lat_cycle0", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2", 32'(out_valid), 32'd1);
    tick();
    drain();

    // Saturation: 20 zero words
    for (int i = 0; i < 20; i++) send(32'h0, 6'd32);
    drain();
    check("cnt16_20", 32'(zero_cnt), 32'd20);
    check("cnt4_sat", 32'(zero_cnt_s), 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 32'd0, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
